// File: rtl/crp16_mux_pkg.sv
// Shared constants, FSM state type and index-width helpers for the CRP16
// streaming multiplexer family.
package crp16_mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } mux_state_e;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < n) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Index width never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority encoder: the first set request at or after
// `start` (wrapping at n-1 -> 0) wins.
module rr_priority_picker #(
    parameter int n = 4,
    parameter int w = 2
) (
    input  logic [n-1:0] req,
    input  logic [w-1:0] start,
    output logic [n-1:0] grant,
    output logic [w-1:0] idx,
    output logic         any
);

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

    // Scan offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        idx = {w{1'b0}};
        any = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            if (req[w'(wrap_idx(int'(start), i))]) begin
                idx = w'(wrap_idx(int'(start), i));
                any = 1'b1;
            end else begin
                idx = idx;
                any = any;
            end
        end
    end

    // Expand the winning index to a one-hot grant vector.
    always_comb begin
        grant = {n{1'b0}};
        for (int k = 0; k < n; k++) begin
            grant[k] = any & (idx == w'(k));
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-to-1 valid/ready stream multiplexer with fixed or round-robin arbitration,
// optional packet lock, and a one-entry registered output stage.
module rr_stream_mux
    import crp16_mux_pkg::*;
#(
    parameter int bits     = 16,
    parameter int channels = 16,
    parameter int mode     = 1,
    parameter int packet   = 0
) (
    input  logic                                clock,
    input  logic                                resetn,
    input  logic [channels*bits-1:0]            in_data,
    input  logic [channels-1:0]                 in_last,
    input  logic [channels-1:0]                 in_valid,
    output logic [channels-1:0]                 in_ready,
    output logic [bits-1:0]                     out_data,
    output logic                                out_last,
    output logic [idx_width(channels)-1:0]      out_channel,
    output logic                                out_valid,
    input  logic                                out_ready
);

    localparam int IW = idx_width(channels);

    mux_state_e          state_r;
    mux_state_e          state_nxt_s;
    logic [IW-1:0]       lock_idx_r;
    logic [IW-1:0]       lock_idx_nxt_s;
    logic [IW-1:0]       ptr_r;
    logic [IW-1:0]       ptr_nxt_s;
    logic [IW-1:0]       start_s;

    logic [channels-1:0] pick_grant_s;
    logic [IW-1:0]       pick_idx_s;
    logic                pick_any_s;

    logic                load_s;
    logic [channels-1:0] ready_vec_s;
    logic [IW-1:0]       grant_idx_s;
    logic                grant_any_s;
    logic                xfer_s;
    logic [bits-1:0]     grant_data_s;
    logic                grant_last_s;

    // Fixed priority always searches from channel 0.
    always_comb begin
        if (mode == MODE_RR) begin
            start_s = ptr_r;
        end else begin
            start_s = {IW{1'b0}};
        end
    end

    rr_priority_picker #(
        .n (channels),
        .w (IW)
    ) u_picker (
        .req   (in_valid),
        .start (start_s),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // While locked only the owning channel may be granted, even if idle.
    always_comb begin
        ready_vec_s = {channels{1'b0}};
        grant_idx_s = pick_idx_s;
        grant_any_s = pick_any_s;
        case (state_r)
            ST_ARB: begin
                ready_vec_s = pick_grant_s;
            end
            ST_LOCKED: begin
                grant_idx_s = lock_idx_r;
                for (int k = 0; k < channels; k++) begin
                    ready_vec_s[k] = in_valid[k] & (lock_idx_r == IW'(k));
                end
                grant_any_s = |ready_vec_s;
            end
            default: begin
                grant_any_s = 1'b0;
            end
        endcase
    end

    assign load_s   = ~out_valid | out_ready;
    assign xfer_s   = load_s & grant_any_s;
    assign in_ready = load_s ? ready_vec_s : {channels{1'b0}};

    // Constant-index data/last mux keyed by the granted channel.
    always_comb begin
        grant_data_s = {bits{1'b0}};
        grant_last_s = 1'b0;
        for (int k = 0; k < channels; k++) begin
            if (grant_idx_s == IW'(k)) begin
                grant_data_s = in_data[k*bits +: bits];
                grant_last_s = in_last[k];
            end else begin
                grant_data_s = grant_data_s;
                grant_last_s = grant_last_s;
            end
        end
    end

    // Lock state and round-robin pointer next-state logic.
    always_comb begin
        state_nxt_s    = state_r;
        lock_idx_nxt_s = lock_idx_r;
        ptr_nxt_s      = ptr_r;
        case (state_r)
            ST_ARB: begin
                if ((packet != 0) && xfer_s && !grant_last_s) begin
                    state_nxt_s    = ST_LOCKED;
                    lock_idx_nxt_s = grant_idx_s;
                end else begin
                    state_nxt_s    = ST_ARB;
                end
                if ((mode == MODE_RR) && xfer_s) begin
                    ptr_nxt_s = (grant_idx_s == IW'(channels - 1)) ?
                                {IW{1'b0}} : (grant_idx_s + IW'(1));
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            ST_LOCKED: begin
                if (xfer_s && grant_last_s) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_ARB;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_ARB;
            lock_idx_r <= {IW{1'b0}};
            ptr_r      <= {IW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            lock_idx_r <= lock_idx_nxt_s;
            ptr_r      <= ptr_nxt_s;
        end
    end

    // One-entry output stage; a drain and a new load in one cycle keep it full.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_data    <= {bits{1'b0}};
            out_last    <= 1'b0;
            out_channel <= {IW{1'b0}};
            out_valid   <= 1'b0;
        end else if (xfer_s) begin
            out_data    <= grant_data_s;
            out_last    <= grant_last_s;
            out_channel <= grant_idx_s;
            out_valid   <= 1'b1;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end else begin
            out_valid   <= out_valid;
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench: three configurations (4ch RR packet, 4ch fixed, 16ch RR).
module tb_rr_stream_mux;

    logic clock;
    logic resetn;
    int   n_tests;
    int   n_fail;

    // Instance A: 4 channels, round-robin, packet lock
    logic [63:0] a_data;
    logic [3:0]  a_last, a_valid, a_ready;
    logic [15:0] a_odata;
    logic        a_olast, a_ovalid, a_oready;
    logic [1:0]  a_och;

    // Instance B: 4 channels, fixed priority, no lock
    logic [63:0] b_data;
    logic [3:0]  b_last, b_valid, b_ready;
    logic [15:0] b_odata;
    logic        b_olast, b_ovalid, b_oready;
    logic [1:0]  b_och;

    // Instance C: 16 channels, round-robin, no lock
    logic [255:0] c_data;
    logic [15:0]  c_last, c_valid, c_ready;
    logic [15:0]  c_odata;
    logic         c_olast, c_ovalid, c_oready;
    logic [3:0]   c_och;

    rr_stream_mux #(.bits(16), .channels(4), .mode(1), .packet(1)) u_a (
        .clock(clock), .resetn(resetn), .in_data(a_data), .in_last(a_last),
        .in_valid(a_valid), .in_ready(a_ready), .out_data(a_odata),
        .out_last(a_olast), .out_channel(a_och), .out_valid(a_ovalid),
        .out_ready(a_oready));

    rr_stream_mux #(.bits(16), .channels(4), .mode(0), .packet(0)) u_b (
        .clock(clock), .resetn(resetn), .in_data(b_data), .in_last(b_last),
        .in_valid(b_valid), .in_ready(b_ready), .out_data(b_odata),
        .out_last(b_olast), .out_channel(b_och), .out_valid(b_ovalid),
        .out_ready(b_oready));

    rr_stream_mux #(.bits(16), .channels(16), .mode(1), .packet(0)) u_c (
        .clock(clock), .resetn(resetn), .in_data(c_data), .in_last(c_last),
        .in_valid(c_valid), .in_ready(c_ready), .out_data(c_odata),
        .out_last(c_olast), .out_channel(c_och), .out_valid(c_ovalid),
        .out_ready(c_oready));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0]  exp_ch;
        logic [15:0] exp_d;
        resetn   = 1'b0;
        a_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        a_valid  = 4'hF;
        a_last   = 4'hF;
        a_oready = 1'b1;
        #12;
        n_tests++;
        if (a_ovalid !== 1'b0 || a_odata !== 16'h0000 || a_och !== 2'd0 || a_olast !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b d=%h ch=%0d l=%b exp all 0", a_ovalid, a_odata, a_och, a_olast);
        end
        tick();
        resetn = 1'b1;
        n_tests++;
        if (a_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_ready got %b exp 0001", a_ready);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_ch = 2'(k % 4);
            exp_d  = 16'hA000 + 16'(k % 4);
            n_tests++;
            if (a_och !== exp_ch || a_odata !== exp_d || a_ovalid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_seq[%0d] got ch=%0d d=%h v=%b exp ch=%0d d=%h v=1", k, a_och, a_odata, a_ovalid, exp_ch, exp_d);
            end
        end
    endtask

    task automatic test_packet();
        // pointer is 1 here; ch2 wins ahead of ch0 and then holds the grant
        a_valid = 4'b0101;
        a_last  = 4'b1011;
        #1;
        n_tests++;
        if (a_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL pkt_first_ready got %b exp 0100", a_ready);
        end
        tick();
        n_tests++;
        if (a_och !== 2'd2 || a_olast !== 1'b0 || a_odata !== 16'hA002) begin
            n_fail++;
            $display("FAIL pkt_beat1 got ch=%0d l=%b d=%h exp ch=2 l=0 d=a002", a_och, a_olast, a_odata);
        end
        n_tests++;
        if (a_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL pkt_locked_ready got %b exp 0100", a_ready);
        end
        tick();
        n_tests++;
        if (a_och !== 2'd2) begin
            n_fail++;
            $display("FAIL pkt_beat2 got ch=%0d exp 2", a_och);
        end
        a_last = 4'b1111;
        tick();
        n_tests++;
        if (a_och !== 2'd2 || a_olast !== 1'b1) begin
            n_fail++;
            $display("FAIL pkt_beat3 got ch=%0d l=%b exp ch=2 l=1", a_och, a_olast);
        end
        n_tests++;
        if (u_a.ptr_r !== 2'd3) begin
            n_fail++;
            $display("FAIL pkt_ptr got %0d exp 3", u_a.ptr_r);
        end
        a_valid = 4'b0001;
        tick();
        n_tests++;
        if (a_och !== 2'd0 || a_odata !== 16'hA000) begin
            n_fail++;
            $display("FAIL pkt_after got ch=%0d d=%h exp ch=0 d=a000", a_och, a_odata);
        end
    endtask

    task automatic test_fixed();
        b_data   = {16'h3333, 16'h0000, 16'h1111, 16'h0000};
        b_valid  = 4'b1010;
        b_last   = 4'b0000;
        b_oready = 1'b1;
        #1;
        n_tests++;
        if (b_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL fixed_ready0 got %b exp 0010", b_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (b_och !== 2'd1 || b_odata !== 16'h1111 || b_ready !== 4'b0010) begin
                n_fail++;
                $display("FAIL fixed_beat[%0d] got ch=%0d d=%h rdy=%b exp ch=1 d=1111 rdy=0010", k, b_och, b_odata, b_ready);
            end
        end
    endtask

    task automatic test_back_pressure();
        b_oready = 1'b0;
        b_data   = {16'h3333, 16'h0000, 16'h1112, 16'h0000};
        #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (b_ready !== 4'b0000 || b_odata !== 16'h1111 || b_ovalid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got rdy=%b d=%h v=%b exp rdy=0000 d=1111 v=1", k, b_ready, b_odata, b_ovalid);
            end
            tick();
        end
        b_oready = 1'b1;
        #1;
        n_tests++;
        if (b_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_release_ready got %b exp 0010", b_ready);
        end
        tick();
        n_tests++;
        if (b_odata !== 16'h1112 || b_ovalid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_next got d=%h v=%b exp d=1112 v=1", b_odata, b_ovalid);
        end
        b_valid = 4'b1000;
        tick();
        n_tests++;
        if (b_och !== 2'd3 || b_odata !== 16'h3333 || b_ovalid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_switch got ch=%0d d=%h v=%b exp ch=3 d=3333 v=1", b_och, b_odata, b_ovalid);
        end
        b_valid = 4'b0000;
        tick();
        n_tests++;
        if (b_ovalid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain got v=%b exp 0", b_ovalid);
        end
    endtask

    task automatic test_rr_wrap();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'd15;
        exp_seq[1] = 4'd0;
        exp_seq[2] = 4'd15;
        c_oready = 1'b1;
        c_valid  = 16'h4000;
        tick();
        n_tests++;
        if (c_och !== 4'd14) begin
            n_fail++;
            $display("FAIL wrap_setup got ch=%0d exp 14", c_och);
        end
        c_valid = 16'h8001;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (c_och !== exp_seq[k] || c_ovalid !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap[%0d] got ch=%0d v=%b exp ch=%0d v=1", k, c_och, c_ovalid, exp_seq[k]);
            end
        end
        c_valid = 16'h0000;
    endtask

    task automatic test_reset_locked();
        a_valid = 4'b0010;
        a_last  = 4'b1101;
        tick();
        n_tests++;
        if (a_och !== 2'd1 || a_ovalid !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_setup got ch=%0d v=%b exp ch=1 v=1", a_och, a_ovalid);
        end
        a_valid = 4'b1111;
        #1;
        n_tests++;
        if (a_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL lock_only_owner got %b exp 0010", a_ready);
        end
        #1;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (a_ovalid !== 1'b0 || a_och !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b ch=%0d exp v=0 ch=0", a_ovalid, a_och);
        end
        #1;
        resetn = 1'b1;
        a_last = 4'b1111;
        #1;
        n_tests++;
        if (a_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL post_reset_ready got %b exp 0001", a_ready);
        end
        tick();
        n_tests++;
        if (a_och !== 2'd0 || a_ovalid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_grant got ch=%0d v=%b exp ch=0 v=1", a_och, a_ovalid);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        b_data   = 64'h0;
        b_last   = 4'h0;
        b_valid  = 4'h0;
        b_oready = 1'b1;
        c_data   = 256'h0;
        c_last   = 16'h0;
        c_valid  = 16'h0;
        c_oready = 1'b1;
        test_reset();
        test_packet();
        test_fixed();
        test_back_pressure();
        test_rr_wrap();
        test_reset_locked();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-to-1 streaming multiplexer with built-in arbitration, successor to the fixed 16-to-1 select mux. Instead of an external select, it arbitrates among valid/ready input channels (fixed-priority or round-robin), optionally locks the grant for multi-beat packets, and registers the winner into a one-entry output stage. Used wherever several CRP16 agents, such as register-file write ports and bus masters, share one 16-bit datapath.

## Interface
- `bits`, 16, data width per channel (≥1)
- `channels`, 16, number of input channels (≥2)
- `mode`, 1, 0 = fixed priority (lowest index wins); 1 = round-robin
- `packet`, 0, 1 = hold grant until a beat with `last`=1; 0 = re-arbitrate every beat
- `clock`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `in_data`  in  channels*bits  channel k at bits [k*bits +: bits]
- `in_last`  in  channels  end-of-packet flag per channel (ignored when `packet`=0)
- `in_valid`  in  channels  per-channel valid
- `in_ready`  out  channels  per-channel ready (one-hot or zero)
- `out_data`  out  bits  registered selected data
- `out_last`  out  1  registered last flag
- `out_channel`  out  max(1,clog2(channels))  index of the source of `out_data`
- `out_valid`  out  1  output register holds a beat
- `out_ready`  in  1  downstream accepts

## Operation
- Transfer on a channel occurs when its valid and ready are both 1 at a rising edge.
- `load` = !`out_valid` | `out_ready`. Grant is computed combinationally from `in_valid`, pointer and lock state; `in_ready[g]` = `load` & `in_valid[g]` for the granted g, all other bits 0. `in_ready` depends on `in_valid`; sources must not depend on ready to assert valid.
- Fixed priority: g = lowest index with `in_valid` set.
- Round-robin: search starts at `ptr`, wraps at channels-1 → 0; after a grant of first beat from channel g, `ptr` ← (g+1) mod channels.
- FSM (only when `packet`=1): ARB → LOCKED(g) when a beat with `last`=0 transfers from g; LOCKED(g) grants only g regardless of other valids; LOCKED → ARB when a beat with `last`=1 transfers from g. `ptr` does not move while LOCKED. When `packet`=0 the FSM stays in ARB.
- Output register loads data/last/channel on a transfer; `out_valid` ← 1 on transfer, ← 0 when drained (`out_ready`=1) with no new transfer.
- No valid input while `load`=1 → no grant, `in_ready`=0.

## Timing
- Latency: input transfer at edge t → `out_valid`=1 from t; observed on output in cycle after t.
- Throughput: one beat per cycle with `out_ready` held at 1; back-to-back channel switches allowed with no bubble.
- Back-pressure: `out_ready`=0 with `out_valid`=1 → all `in_ready`=0; outputs held stable.
- Reset (asynchronous assert, synchronous-safe release): `out_valid`=0, `out_data`=0, `out_last`=0, `out_channel`=0, `ptr`=0, FSM=ARB. Reset mid-packet abandons the lock; no partial beat survives.
- Simultaneous drain and load in the same cycle: new beat replaces old, `out_valid` stays 1.
- LOCKED channel deasserting valid mid-packet: stall (no grant) until it returns; other channels are not served.

## Structure
- Shared package `crp16_mux_pkg`: `MODE_FIXED`=0, `MODE_RR`=1 constants, FSM state enum (ARB, LOCKED), clog2 helper function.
- One sub-module `rr_priority_picker`: combinational rotate-priority encoder (inputs: request vector, start index; outputs: one-hot grant, index, any). Fixed mode ties start to 0.
- Top holds `ptr`, FSM, lock index, output register.

## Test plan
- Reset with `channels`=4, `mode`=1, all valids 1 → outputs 0; release and hold `out_ready`=1 → `out_channel` sequence 0,1,2,3,0 on consecutive cycles.
- `mode`=0, valids 0b1010, data ch1=0x1111, ch3=0x3333 → ch1 granted every cycle; ch3 never ready while ch1 is valid.
- `out_ready`=0 for 3 cycles with `out_valid`=1 → `in_ready`=0, `out_data` stable; on release, the next beat follows with no bubble.
- `packet`=1, ch2 sends 3 beats (last on 3rd) while ch0 is valid → out_channel 2,2,2 then 0; `ptr`=3 after the packet.
- Round-robin wrap: `channels`=16, only ch15 and ch0 valid, `ptr`=15 → grant order 15,0,15.
- Assert `resetn`=0 while LOCKED on ch1 → `out_valid` drops immediately; after release, ch0 (lowest from `ptr`=0) wins.
